// File: rtl/regfile_write_arbiter.sv
// Two-requester write front end for the 32x64 register file: per-source FIFOs
// drained round-robin into a registered write port, plus a pending-destination mask.
module regfile_write_arbiter #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         a_valid,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [4:0]   b_addr,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  output logic [N-1:0] D,
  output logic [4:0]   DA,
  output logic         W,
  output logic         grant,
  output logic [31:0]  busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [4:0] ZERO_REG = 5'd31;
  typedef logic [PW:0] ptr_t;

  logic [1:0]   in_valid;
  logic [4:0]   in_addr [2];
  logic [N-1:0] in_data [2];

  logic [4:0]   addr_q [2][DEPTH];
  logic [N-1:0] data_q [2][DEPTH];
  ptr_t         wr_q [2];
  ptr_t         rd_q [2];

  logic [1:0]   full, empty, ready, push, pop;
  logic         issue, sel_b;
  logic [4:0]   head_addr;
  logic [N-1:0] head_data;

  logic         last_q;
  logic         w_q, grant_q;
  logic [N-1:0] d_q;
  logic [4:0]   da_q;
  logic [31:0]  busy_mask;

  assign in_valid   = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  // Physical slot j holds a live entry when its distance from the head is below the occupancy.
  function automatic logic slot_live(input ptr_t wr, input ptr_t rd, input int j);
    ptr_t cnt;
    ptr_t offs;
    cnt  = wr - rd;
    offs = (ptr_t'(j) - rd) & ptr_t'(DEPTH - 1);
    return offs < cnt;
  endfunction

  always_comb begin
    full  = '0;
    empty = '0;
    ready = '0;
    push  = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]  = (wr_q[s][PW] != rd_q[s][PW]) && (wr_q[s][PW-1:0] == rd_q[s][PW-1:0]);
      empty[s] = (wr_q[s] == rd_q[s]);
      ready[s] = !full[s] && !reset;
      push[s]  = in_valid[s] && ready[s] && (in_addr[s] != ZERO_REG);
    end
    issue     = !(empty[0] && empty[1]);
    // last_q=1 means B was granted last, so a tie goes to A.
    sel_b     = !empty[1] && (empty[0] || !last_q);
    pop       = {issue && sel_b, issue && !sel_b};
    head_addr = sel_b ? addr_q[1][rd_q[1][PW-1:0]] : addr_q[0][rd_q[0][PW-1:0]];
    head_data = sel_b ? data_q[1][rd_q[1][PW-1:0]] : data_q[0][rd_q[0][PW-1:0]];
  end

  // Stage: FIFO entry storage
  always_ff @(posedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        addr_q[s][wr_q[s][PW-1:0]] <= in_addr[s];
        data_q[s][wr_q[s][PW-1:0]] <= in_data[s];
      end
    end
  end

  // Stage: pointers, arbitration state and the registered write port
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_q[s] <= '0;
        rd_q[s] <= '0;
      end
      w_q     <= 1'b0;
      d_q     <= '0;
      da_q    <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_q[s] <= wr_q[s] + ptr_t'(1);
        if (pop[s])  rd_q[s] <= rd_q[s] + ptr_t'(1);
      end
      w_q <= issue;
      if (issue) begin
        d_q     <= head_data;
        da_q    <= head_addr;
        grant_q <= sel_b;
        last_q  <= sel_b;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (slot_live(wr_q[s], rd_q[s], j)) busy_mask[addr_q[s][j]] = 1'b1;
      end
    end
    if (w_q) busy_mask[da_q] = 1'b1;
    busy_mask[ZERO_REG] = 1'b0;
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign D       = d_q;
  assign DA      = da_q;
  assign W       = w_q;
  assign grant   = grant_q;
  assign busy    = busy_mask;
endmodule
